// File: rtl/sd_pkg.sv
// Shared definitions for the SD data-line receive path: state encoding,
// default block geometry and the CRC16 generator polynomial.
package sd_pkg;

    localparam int          SD_BLOCK_BYTES_DEFAULT = 512;
    localparam int          SD_DAT_TIMEOUT_DEFAULT = 65535;
    localparam logic [15:0] SD_CRC16_POLY          = 16'h1021;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_DATA,
        ST_CRC,
        ST_END
    } sd_dat_state_t;

endpackage

// File: rtl/crc16.sv
// Serial CRC16 (x^16+x^12+x^5+1) generator, one bit per clock, MSB-first.
// Feeding a message followed by its own CRC leaves a zero remainder.
module crc16
    import sd_pkg::*;
(
    input  logic        iclk,
    input  logic        irst,
    input  logic        idat,
    output logic [15:0] ocrc
);

    logic feedback;

    assign feedback = idat ^ ocrc[15];

    always_ff @(posedge iclk) begin
        if (irst) begin
            ocrc <= '0;
        end else begin
            ocrc <= {ocrc[14:0], 1'b0} ^ (feedback ? SD_CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/sd_dat_rx.sv
// 1-bit SD DAT0 block receiver: waits for a start bit, deserializes a block
// MSB-first, then checks the trailing CRC16 and the end bit.
module sd_dat_rx
    import sd_pkg::*;
#(
    parameter int BLOCK_BYTES = SD_BLOCK_BYTES_DEFAULT,
    parameter int TIMEOUT     = SD_DAT_TIMEOUT_DEFAULT
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       istart,
    input  logic       idat,
    output logic [7:0] odata,
    output logic       odata_valid,
    output logic       odone,
    output logic       ocrc_err,
    output logic       oend_err,
    output logic       otimeout,
    output logic       obusy
);

    localparam int BYTE_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BLOCK_BYTES - 1);
    localparam logic [TO_W-1:0]   LAST_WAIT = TO_W'(TIMEOUT - 1);

    sd_dat_state_t     state;
    sd_dat_state_t     state_next;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic [3:0]        crc_cnt;
    logic [TO_W-1:0]   wait_cnt;
    logic [6:0]        shreg;
    logic [15:0]       crc_rem;
    logic              crc_rst;

    // The CRC only runs from the first data bit onwards, so it sits in reset
    // until the start bit has been seen.
    assign crc_rst = irst | (state == ST_IDLE) | (state == ST_WAIT_START);
    assign obusy   = (state != ST_IDLE);

    crc16 u_crc16 (
        .iclk (iclk),
        .irst (crc_rst),
        .idat (idat),
        .ocrc (crc_rem)
    );

    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (istart) state_next = ST_WAIT_START;
            end
            // A start bit on the final counted cycle takes priority over the timeout.
            ST_WAIT_START: begin
                if (!idat) begin
                    state_next = ST_DATA;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if ((bit_cnt == 3'd7) && (byte_cnt == LAST_BYTE)) state_next = ST_CRC;
            end
            ST_CRC: begin
                if (crc_cnt == 4'd15) state_next = ST_END;
            end
            ST_END:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            crc_cnt     <= '0;
            wait_cnt    <= '0;
            shreg       <= '0;
            odata       <= '0;
            odata_valid <= 1'b0;
            odone       <= 1'b0;
            ocrc_err    <= 1'b0;
            oend_err    <= 1'b0;
            otimeout    <= 1'b0;
        end else begin
            odata_valid <= 1'b0;
            odone       <= 1'b0;
            otimeout    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (istart) begin
                        ocrc_err <= 1'b0;
                        oend_err <= 1'b0;
                    end
                end
                ST_WAIT_START: begin
                    if (!idat) begin
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        crc_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == LAST_WAIT) otimeout <= 1'b1;
                    end
                end
                ST_DATA: begin
                    shreg   <= {shreg[5:0], idat};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        odata       <= {shreg, idat};
                        odata_valid <= 1'b1;
                        if (byte_cnt != LAST_BYTE) byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                ST_CRC: begin
                    if (crc_cnt != 4'd15) crc_cnt <= crc_cnt + 4'd1;
                end
                // crc_rem here already covers every data and CRC bit; the end bit is not part of it.
                ST_END: begin
                    oend_err <= ~idat;
                    ocrc_err <= |crc_rem;
                    odone    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dat_rx.sv
// Scoreboard bench for sd_dat_rx: a 512-byte instance and an 8-byte instance,
// each with a 100-cycle start-bit timeout.
module tb_sd_dat_rx;

    typedef struct {
        int         inst;
        int         kind;
        logic [7:0] data;
        logic       crc_err;
        logic       end_err;
    } exp_t;

    localparam int EV_DATA    = 0;
    localparam int EV_DONE    = 1;
    localparam int EV_TIMEOUT = 2;

    logic       iclk = 1'b0;
    logic       irst        [2];
    logic       istart      [2];
    logic       idat        [2];
    logic [7:0] odata       [2];
    logic       odata_valid [2];
    logic       odone       [2];
    logic       ocrc_err    [2];
    logic       oend_err    [2];
    logic       otimeout    [2];
    logic       obusy       [2];

    logic [7:0] blk [512];
    exp_t       exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 iclk = ~iclk;

    sd_dat_rx #(.BLOCK_BYTES(512), .TIMEOUT(100)) dut_big (
        .iclk (iclk), .irst (irst[0]), .istart (istart[0]), .idat (idat[0]),
        .odata (odata[0]), .odata_valid (odata_valid[0]), .odone (odone[0]),
        .ocrc_err (ocrc_err[0]), .oend_err (oend_err[0]), .otimeout (otimeout[0]),
        .obusy (obusy[0])
    );

    sd_dat_rx #(.BLOCK_BYTES(8), .TIMEOUT(100)) dut_small (
        .iclk (iclk), .irst (irst[1]), .istart (istart[1]), .idat (idat[1]),
        .odata (odata[1]), .odata_valid (odata_valid[1]), .odone (odone[1]),
        .ocrc_err (ocrc_err[1]), .oend_err (oend_err[1]), .otimeout (otimeout[1]),
        .obusy (obusy[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input int k, input int kind, input logic [7:0] d,
                            input logic ce, input logic ee);
        exp_t e;
        e.inst    = k;
        e.kind    = kind;
        e.data    = d;
        e.crc_err = ce;
        e.end_err = ee;
        exp_q.push_back(e);
    endtask

    task automatic match_event(input int k, input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL unexpected_event: inst %0d kind %0d appeared, none required (t=%0t)",
                     k, kind, $time);
        end else begin
            e = exp_q.pop_front();
            checkOutput("event_inst", k, e.inst);
            checkOutput("event_kind", kind, e.kind);
            if (kind == EV_DATA) checkOutput("odata", {24'h0, odata[k]}, {24'h0, e.data});
            if (kind == EV_DONE) begin
                checkOutput("ocrc_err_at_done", {31'h0, ocrc_err[k]}, {31'h0, e.crc_err});
                checkOutput("oend_err_at_done", {31'h0, oend_err[k]}, {31'h0, e.end_err});
            end
            if (kind != EV_DATA) checkOutput("obusy_at_finish", {31'h0, obusy[k]}, 32'h0);
        end
    endtask

    // Monitor: every strobe/pulse the DUTs present is matched against the queue.
    always @(negedge iclk) begin
        for (int k = 0; k < 2; k++) begin
            if (odata_valid[k]) match_event(k, EV_DATA);
            if (odone[k])       match_event(k, EV_DONE);
            if (otimeout[k])    match_event(k, EV_TIMEOUT);
        end
    end

    // Byte-wise CRC-16/XMODEM over blk[0..n-1].
    function automatic logic [15:0] crc_calc(input int n);
        logic [15:0] c;
        c = 16'h0000;
        for (int i = 0; i < n; i++) begin
            c = c ^ {blk[i], 8'h00};
            for (int j = 0; j < 8; j++) begin
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic send_bit(input int k, input logic b);
        idat[k] = b;
        @(negedge iclk);
    endtask

    task automatic arm(input int k);
        istart[k] = 1'b1;
        idat[k]   = 1'b1;
        @(negedge iclk);
        istart[k] = 1'b0;
    endtask

    task automatic send_byte(input int k, input logic [7:0] b, input logic poke);
        push_exp(k, EV_DATA, b, 1'b0, 1'b0);
        for (int j = 7; j >= 0; j--) begin
            istart[k] = poke && (j == 7);
            send_bit(k, b[j]);
        end
        istart[k] = 1'b0;
    endtask

    task automatic applyStimulus(input int k, input int nbytes, input int idles,
                                 input logic [15:0] crc, input logic endb,
                                 input logic exp_ce, input logic exp_ee, input int poke_at);
        repeat (idles) send_bit(k, 1'b1);
        send_bit(k, 1'b0);
        for (int i = 0; i < nbytes; i++) send_byte(k, blk[i], i == poke_at);
        for (int j = 15; j >= 0; j--) send_bit(k, crc[j]);
        push_exp(k, EV_DONE, 8'h00, exp_ce, exp_ee);
        send_bit(k, endb);
        idat[k] = 1'b1;
    endtask

    task automatic check_all_zero(input int k, input string tag);
        checkOutput({tag, "_odata"},       {24'h0, odata[k]}, 32'h0);
        checkOutput({tag, "_odata_valid"}, {31'h0, odata_valid[k]}, 32'h0);
        checkOutput({tag, "_odone"},       {31'h0, odone[k]}, 32'h0);
        checkOutput({tag, "_ocrc_err"},    {31'h0, ocrc_err[k]}, 32'h0);
        checkOutput({tag, "_oend_err"},    {31'h0, oend_err[k]}, 32'h0);
        checkOutput({tag, "_otimeout"},    {31'h0, otimeout[k]}, 32'h0);
        checkOutput({tag, "_obusy"},       {31'h0, obusy[k]}, 32'h0);
    endtask

    initial begin
        logic [15:0] crc8;
        for (int k = 0; k < 2; k++) begin
            irst[k]   = 1'b1;
            istart[k] = 1'b0;
            idat[k]   = 1'b1;
        end
        repeat (3) @(negedge iclk);
        check_all_zero(0, "reset_big");
        check_all_zero(1, "reset_small");
        irst[0] = 1'b0;
        irst[1] = 1'b0;
        @(negedge iclk);

        $display("[TB] good 512-byte block of 8'hFF");
        for (int i = 0; i < 512; i++) blk[i] = 8'hFF;
        arm(0);
        applyStimulus(0, 512, 10, 16'h7FA1, 1'b1, 1'b0, 1'b0, -1);
        repeat (2) @(negedge iclk);
        checkOutput("good_obusy_after", {31'h0, obusy[0]}, 32'h0);
        checkOutput("good_ocrc_err_after", {31'h0, ocrc_err[0]}, 32'h0);

        $display("[TB] corrupted CRC");
        arm(0);
        applyStimulus(0, 512, 10, 16'h7FA0, 1'b1, 1'b1, 1'b0, -1);
        repeat (5) @(negedge iclk);
        checkOutput("crc_err_held", {31'h0, ocrc_err[0]}, 32'h1);
        arm(0);
        checkOutput("crc_err_cleared_by_istart", {31'h0, ocrc_err[0]}, 32'h0);
        checkOutput("obusy_after_arm", {31'h0, obusy[0]}, 32'h1);

        $display("[TB] framing error");
        applyStimulus(0, 512, 10, 16'h7FA1, 1'b0, 1'b0, 1'b1, -1);
        repeat (3) @(negedge iclk);
        checkOutput("end_err_held", {31'h0, oend_err[0]}, 32'h1);
        arm(0);
        checkOutput("end_err_cleared_by_istart", {31'h0, oend_err[0]}, 32'h0);

        $display("[TB] istart pulsed during DATA");
        applyStimulus(0, 512, 5, 16'h7FA1, 1'b1, 1'b0, 1'b0, 100);
        repeat (20) send_bit(0, 1'b0);
        checkOutput("no_rearm_obusy", {31'h0, obusy[0]}, 32'h0);
        idat[0] = 1'b1;

        $display("[TB] start-bit timeout");
        arm(1);
        repeat (99) send_bit(1, 1'b1);
        checkOutput("timeout_not_early", {31'h0, otimeout[1]}, 32'h0);
        checkOutput("busy_before_timeout", {31'h0, obusy[1]}, 32'h1);
        push_exp(1, EV_TIMEOUT, 8'h00, 1'b0, 1'b0);
        send_bit(1, 1'b1);
        repeat (5) send_bit(1, 1'b1);
        checkOutput("idle_after_timeout", {31'h0, obusy[1]}, 32'h0);

        $display("[TB] start bit on the last counted cycle");
        for (int i = 0; i < 8; i++) blk[i] = 8'(i);
        crc8 = crc_calc(8);
        arm(1);
        repeat (99) send_bit(1, 1'b1);
        applyStimulus(1, 8, 0, crc8, 1'b1, 1'b0, 1'b0, -1);
        repeat (3) @(negedge iclk);
        checkOutput("odata_holds_last", {24'h0, odata[1]}, 32'h07);

        $display("[TB] reset in the middle of a block");
        arm(1);
        send_bit(1, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(1, blk[i], 1'b0);
        irst[1] = 1'b1;
        idat[1] = 1'b0;
        @(negedge iclk);
        check_all_zero(1, "midblock_reset");
        irst[1] = 1'b0;
        repeat (20) send_bit(1, 1'b1);
        checkOutput("idle_after_reset", {31'h0, obusy[1]}, 32'h0);
        arm(1);
        applyStimulus(1, 8, 3, crc8, 1'b1, 1'b0, 1'b0, -1);

        repeat (5) @(negedge iclk);
        checkOutput("scoreboard_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
